// File: rtl/alu_req_sequencer_pkg.sv
// alu_req_sequencer_pkg: opcodes, ALU selects and sequencer states
package alu_req_sequencer_pkg;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_XOR = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_INC = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   localparam logic [2:0] SEL_ADD = 3'd0;
   localparam logic [2:0] SEL_SUB = 3'd1;
   localparam logic [2:0] SEL_XOR = 3'd2;
   localparam logic [2:0] SEL_AND = 3'd3;
   localparam logic [2:0] SEL_OR  = 3'd4;
   localparam logic [2:0] SEL_INC = 3'd5;
   localparam logic [2:0] SEL_SHL = 3'd6;
   localparam logic [2:0] SEL_SHR = 3'd7;

   typedef enum logic [2:0] {IDLE, EXEC, MUL_ADD, MUL_SHL, RESP} state_t;

   function automatic logic op_illegal(input logic [3:0] op);
      return op > OP_MUL;
   endfunction
endpackage

// File: rtl/alu_req_sequencer_if.sv
// alu_req_sequencer_if: two request channels, response channel and busy status
interface alu_req_sequencer_if #(
   parameter int TAG_W  = 4,
   parameter int DATA_W = 16
) ();
   logic              r0_valid, r0_ready;
   logic [3:0]        r0_op;
   logic [DATA_W-1:0] r0_a, r0_b;
   logic [TAG_W-1:0]  r0_tag;
   logic              r1_valid, r1_ready;
   logic [3:0]        r1_op;
   logic [DATA_W-1:0] r1_a, r1_b;
   logic [TAG_W-1:0]  r1_tag;
   logic              rsp_valid, rsp_ready;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_zero, rsp_err, rsp_src;
   logic [TAG_W-1:0]  rsp_tag;
   logic              busy;

   modport master (
      output r0_valid, r0_op, r0_a, r0_b, r0_tag,
      output r1_valid, r1_op, r1_a, r1_b, r1_tag,
      input  r0_ready, r1_ready,
      input  rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_src, rsp_tag, busy,
      output rsp_ready
   );

   modport slave (
      input  r0_valid, r0_op, r0_a, r0_b, r0_tag,
      input  r1_valid, r1_op, r1_a, r1_b, r1_tag,
      output r0_ready, r1_ready,
      output rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_src, rsp_tag, busy,
      input  rsp_ready
   );
endinterface

// File: rtl/alu16.sv
// alu16: 16-bit single-cycle ALU with eight operations and a zero flag
module alu16
   import alu_req_sequencer_pkg::*;
(
   input  logic [2:0]  sel_i,
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] y_o,
   output logic        zero_o
);
   // operation select; shifts and increment ignore b
   always_comb begin
      y_o = a_i + b_i;
      case (sel_i)
         SEL_SUB: y_o = a_i - b_i;
         SEL_XOR: y_o = a_i ^ b_i;
         SEL_AND: y_o = a_i & b_i;
         SEL_OR:  y_o = a_i | b_i;
         SEL_INC: y_o = a_i + 16'd1;
         SEL_SHL: y_o = a_i << 1;
         SEL_SHR: y_o = a_i >> 1;
         default: y_o = a_i + b_i;
      endcase
   end

   assign zero_o = (y_o == '0);
endmodule

// File: rtl/alu_req_sequencer_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter with registered priority pointer
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);
   logic ptr_q, ptr_d, pick1;

   // grant the lone requester, or the pointer's choice when both ask
   always_comb begin
      pick1 = req_i[1] & (~req_i[0] | ptr_q);
      gnt_o = en_i ? {pick1, req_i[0] & ~pick1} : 2'b00;
      ptr_d = (|gnt_o) ? gnt_o[0] : ptr_q;
   end

   // pointer moves to the requester that was not just served
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
   end
endmodule

// File: rtl/alu_req_sequencer.sv
// alu_req_sequencer: shares one ALU between two requesters, builds MUL from add/shift passes
module alu_req_sequencer
   import alu_req_sequencer_pkg::*;
#(
   parameter int TAG_W  = 4,
   parameter int DATA_W = 16
) (
   input logic                clk,
   input logic                rst_n,
   alu_req_sequencer_if.slave bus
);
   state_t            state_q, state_d;
   logic [1:0]        gnt;
   logic              accept;
   logic [3:0]        req_op;
   logic [DATA_W-1:0] req_a, req_b;
   logic [TAG_W-1:0]  req_tag;
   logic [2:0]        op_q;
   logic [DATA_W-1:0] a_q, b_q, acc_q, res_q;
   logic [3:0]        cnt_q;
   logic [TAG_W-1:0]  tag_q;
   logic              src_q, zero_q, err_q;
   logic [2:0]        alu_sel;
   logic [DATA_W-1:0] alu_a, alu_b, alu_y;
   logic              alu_zero;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i ({bus.r1_valid, bus.r0_valid}),
      .en_i  (state_q == IDLE),
      .gnt_o (gnt)
   );

   alu16 u_alu (
      .sel_i  (alu_sel),
      .a_i    (alu_a),
      .b_i    (alu_b),
      .y_o    (alu_y),
      .zero_o (alu_zero)
   );

   // select the granted requester's fields
   always_comb begin
      accept  = |gnt;
      req_op  = gnt[1] ? bus.r1_op  : bus.r0_op;
      req_a   = gnt[1] ? bus.r1_a   : bus.r0_a;
      req_b   = gnt[1] ? bus.r1_b   : bus.r0_b;
      req_tag = gnt[1] ? bus.r1_tag : bus.r0_tag;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next state: illegal ops skip straight to RESP, MUL loops 16 add/shift pairs
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = op_illegal(req_op) ? RESP : (req_op == OP_MUL) ? MUL_ADD : EXEC;
         EXEC:    state_d = RESP;
         MUL_ADD: state_d = MUL_SHL;
         MUL_SHL: state_d = (cnt_q == 4'd15) ? RESP : MUL_ADD;
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // outputs: handshakes, response fields and ALU operand steering (zeros when idle)
   always_comb begin
      bus.r0_ready   = gnt[0];
      bus.r1_ready   = gnt[1];
      bus.busy       = (state_q != IDLE);
      bus.rsp_valid  = (state_q == RESP);
      bus.rsp_result = res_q;
      bus.rsp_zero   = zero_q;
      bus.rsp_err    = err_q;
      bus.rsp_src    = src_q;
      bus.rsp_tag    = tag_q;
      alu_sel = (state_q == EXEC) ? op_q : (state_q == MUL_SHL) ? SEL_SHL : SEL_ADD;
      alu_a   = (state_q == EXEC || state_q == MUL_SHL) ? a_q : (state_q == MUL_ADD) ? acc_q : '0;
      alu_b   = (state_q == EXEC) ? b_q : (state_q == MUL_ADD) ? a_q : '0;
   end

   // datapath: capture on accept, a_q doubles as multiplicand and b_q as multiplier
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         tag_q  <= '0;
         src_q  <= 1'b0;
         res_q  <= '0;
         zero_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               op_q  <= req_op[2:0];
               a_q   <= req_a;
               b_q   <= req_b;
               acc_q <= '0;
               cnt_q <= '0;
               tag_q <= req_tag;
               src_q <= gnt[1];
               err_q <= op_illegal(req_op);
               if (op_illegal(req_op)) begin
                  res_q  <= '0;
                  zero_q <= 1'b0;
               end
            end
            EXEC: begin
               res_q  <= alu_y;
               zero_q <= alu_zero;
            end
            MUL_ADD: if (b_q[0]) acc_q <= alu_y;
            MUL_SHL: begin
               a_q   <= alu_y;
               b_q   <= b_q >> 1;
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  res_q  <= acc_q;
                  zero_q <= (acc_q == '0);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_req_sequencer.sv
// tb_alu_req_sequencer: vector table plus scoreboard checks for the ALU request sequencer
module tb_alu_req_sequencer;
   typedef struct {
      logic        src;
      logic [3:0]  op;
      logic [15:0] a, b;
      logic [3:0]  tag;
      logic [15:0] res;
      logic        zero, err;
      int          lat;
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic        zero, err, src;
      logic [3:0]  tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   vec_t vecs[15];

   alu_req_sequencer_if #(.TAG_W(4), .DATA_W(16)) bus ();

   alu_req_sequencer #(.TAG_W(4), .DATA_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) if (rst_n) chk("one_ready", {31'b0, bus.r0_ready & bus.r1_ready}, 32'd0);

   function automatic exp_t mk(input logic [15:0] res, input logic zero, err, src, input logic [3:0] tag);
      exp_t e;
      e.res = res; e.zero = zero; e.err = err; e.src = src; e.tag = tag;
      return e;
   endfunction

   task automatic drive(input logic src, input logic [3:0] op, input logic [15:0] a, b, input logic [3:0] tag);
      if (src) begin
         bus.r1_valid = 1'b1; bus.r1_op = op; bus.r1_a = a; bus.r1_b = b; bus.r1_tag = tag;
      end else begin
         bus.r0_valid = 1'b1; bus.r0_op = op; bus.r0_a = a; bus.r0_b = b; bus.r0_tag = tag;
      end
   endtask

   task automatic wait_ready(input logic src, output bit ok);
      int k;
      k = 0;
      #1;
      while (!(src ? bus.r1_ready : bus.r0_ready) && k < 20) begin
         @(negedge clk);
         #1;
         k++;
      end
      ok = src ? bus.r1_ready : bus.r0_ready;
      chk("accept_seen", {31'b0, ok}, 32'd1);
   endtask

   task automatic wait_rsp(input bit clr, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (clr) begin
            bus.r0_valid = 1'b0;
            bus.r1_valid = 1'b0;
         end
      end while (!bus.rsp_valid && n < 100);
   endtask

   task automatic collect(input string nm);
      exp_t e;
      chk({nm, "_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_sb: response with no expected entry", nm);
      end else begin
         e = sb.pop_front();
         chk({nm, "_result"}, {16'b0, bus.rsp_result}, {16'b0, e.res});
         chk({nm, "_zero"}, {31'b0, bus.rsp_zero}, {31'b0, e.zero});
         chk({nm, "_err"}, {31'b0, bus.rsp_err}, {31'b0, e.err});
         chk({nm, "_src"}, {31'b0, bus.rsp_src}, {31'b0, e.src});
         chk({nm, "_tag"}, {28'b0, bus.rsp_tag}, {28'b0, e.tag});
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk({nm, "_drop"}, {31'b0, bus.rsp_valid}, 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      bit ok;
      int n;
      drive(v.src, v.op, v.a, v.b, v.tag);
      wait_ready(v.src, ok);
      if (!ok) begin
         bus.r0_valid = 1'b0;
         bus.r1_valid = 1'b0;
         return;
      end
      sb.push_back(mk(v.res, v.zero, v.err, v.src, v.tag));
      wait_rsp(1'b1, n);
      chk({nm, "_lat"}, n, v.lat);
      collect(nm);
   endtask

   initial begin
      bit   ok;
      int   n, k;
      logic g;
      bus.r0_valid = 1'b0; bus.r0_op = '0; bus.r0_a = '0; bus.r0_b = '0; bus.r0_tag = '0;
      bus.r1_valid = 1'b0; bus.r1_op = '0; bus.r1_a = '0; bus.r1_b = '0; bus.r1_tag = '0;
      bus.rsp_ready = 1'b0;
      vecs[0]  = '{1'b0, 4'd0,  16'h7FFF, 16'h0001, 4'h3, 16'h8000, 1'b0, 1'b0, 2};
      vecs[1]  = '{1'b1, 4'd1,  16'h0005, 16'h0005, 4'hA, 16'h0000, 1'b1, 1'b0, 2};
      vecs[2]  = '{1'b0, 4'd8,  16'h0123, 16'h0045, 4'h5, 16'h4E6F, 1'b0, 1'b0, 33};
      vecs[3]  = '{1'b0, 4'd8,  16'h0100, 16'h0100, 4'h6, 16'h0000, 1'b1, 1'b0, 33};
      vecs[4]  = '{1'b1, 4'd2,  16'hF0F0, 16'hFF00, 4'h1, 16'h0FF0, 1'b0, 1'b0, 2};
      vecs[5]  = '{1'b0, 4'd3,  16'hF0F0, 16'hFF00, 4'h2, 16'hF000, 1'b0, 1'b0, 2};
      vecs[6]  = '{1'b1, 4'd4,  16'h00F0, 16'h0F00, 4'h4, 16'h0FF0, 1'b0, 1'b0, 2};
      vecs[7]  = '{1'b0, 4'd5,  16'hFFFF, 16'h1234, 4'h7, 16'h0000, 1'b1, 1'b0, 2};
      vecs[8]  = '{1'b1, 4'd6,  16'h8001, 16'h0007, 4'h8, 16'h0002, 1'b0, 1'b0, 2};
      vecs[9]  = '{1'b0, 4'd7,  16'h8001, 16'h0007, 4'h9, 16'h4000, 1'b0, 1'b0, 2};
      vecs[10] = '{1'b1, 4'd8,  16'hFFFF, 16'hFFFF, 4'hB, 16'h0001, 1'b0, 1'b0, 33};
      vecs[11] = '{1'b0, 4'd15, 16'h1111, 16'h2222, 4'hC, 16'h0000, 1'b0, 1'b1, 1};
      vecs[12] = '{1'b1, 4'd9,  16'h0000, 16'h0000, 4'hD, 16'h0000, 1'b0, 1'b1, 1};
      vecs[13] = '{1'b0, 4'd8,  16'h0003, 16'h0000, 4'hE, 16'h0000, 1'b1, 1'b0, 33};
      vecs[14] = '{1'b1, 4'd8,  16'h00FF, 16'h0101, 4'hF, 16'hFFFF, 1'b0, 1'b0, 33};

      repeat (3) @(negedge clk);
      chk("rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_result", {16'b0, bus.rsp_result}, 32'd0);
      chk("rst_zero", {31'b0, bus.rsp_zero}, 32'd0);
      chk("rst_err", {31'b0, bus.rsp_err}, 32'd0);
      chk("rst_src", {31'b0, bus.rsp_src}, 32'd0);
      chk("rst_tag", {28'b0, bus.rsp_tag}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 4'd0, 16'd1, 16'd1, 4'h1);
      drive(1'b1, 4'd0, 16'd2, 16'd2, 4'h2);
      for (int i = 0; i < 3; i++) begin
         k = 0;
         #1;
         while (!(bus.r0_ready || bus.r1_ready) && k < 20) begin
            @(negedge clk);
            #1;
            k++;
         end
         g = bus.r1_ready;
         chk($sformatf("arb_grant%0d", i), {31'b0, g}, (i == 1) ? 32'd1 : 32'd0);
         sb.push_back(g ? mk(16'd4, 1'b0, 1'b0, 1'b1, 4'h2) : mk(16'd2, 1'b0, 1'b0, 1'b0, 4'h1));
         wait_rsp(1'b0, n);
         chk($sformatf("arb%0d_lat", i), n, 2);
         collect($sformatf("arb%0d", i));
      end
      bus.r0_valid = 1'b0;
      bus.r1_valid = 1'b0;
      @(negedge clk);

      drive(1'b0, 4'd12, 16'h1234, 16'h5678, 4'h9);
      wait_ready(1'b0, ok);
      sb.push_back(mk(16'h0000, 1'b0, 1'b1, 1'b0, 4'h9));
      wait_rsp(1'b1, n);
      chk("ill_lat", n, 1);
      drive(1'b1, 4'd0, 16'd3, 16'd4, 4'h7);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
         chk("hold_result", {16'b0, bus.rsp_result}, 32'd0);
         chk("hold_zero", {31'b0, bus.rsp_zero}, 32'd0);
         chk("hold_err", {31'b0, bus.rsp_err}, 32'd1);
         chk("hold_src", {31'b0, bus.rsp_src}, 32'd0);
         chk("hold_tag", {28'b0, bus.rsp_tag}, 32'd9);
         chk("hold_r0_ready", {31'b0, bus.r0_ready}, 32'd0);
         chk("hold_r1_ready", {31'b0, bus.r1_ready}, 32'd0);
         chk("hold_busy", {31'b0, bus.busy}, 32'd1);
         @(negedge clk);
      end
      collect("ill");
      wait_ready(1'b1, ok);
      sb.push_back(mk(16'd7, 1'b0, 1'b0, 1'b1, 4'h7));
      wait_rsp(1'b1, n);
      chk("post_hold_lat", n, 2);
      collect("post_hold");

      drive(1'b0, 4'd8, 16'h0123, 16'h0045, 4'h4);
      wait_ready(1'b0, ok);
      sb.push_back(mk(16'h4E6F, 1'b0, 1'b0, 1'b0, 4'h4));
      @(negedge clk);
      bus.r0_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {31'b0, bus.rsp_valid}, 32'd0);
      chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stale_valid", {31'b0, bus.rsp_valid}, 32'd0);
         chk("stale_busy", {31'b0, bus.busy}, 32'd0);
      end
      drive(1'b0, 4'd0, 16'd10, 16'd1, 4'h1);
      drive(1'b1, 4'd0, 16'd20, 16'd2, 4'h2);
      #1;
      chk("ptr_r0_ready", {31'b0, bus.r0_ready}, 32'd1);
      chk("ptr_r1_ready", {31'b0, bus.r1_ready}, 32'd0);
      bus.r0_valid = 1'b0;
      bus.r1_valid = 1'b0;
      @(negedge clk);
      run_vec('{1'b1, 4'd0, 16'd20, 16'd2, 4'h2, 16'd22, 1'b0, 1'b0, 2}, "post_rst_r1");
      run_vec('{1'b0, 4'd8, 16'd3, 16'd5, 4'h3, 16'd15, 1'b0, 1'b0, 33}, "post_rst_mul");

      chk("sb_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
